// File: rtl/operand_forward_stage_pkg.sv
// Shared constants and helpers for the operand forwarding stage.
// The source-select encoding is 0 for the register file and j+1 for producer j.
package operand_forward_stage_pkg;

  localparam int DEF_XLEN    = 64;
  localparam int DEF_AW      = 5;
  localparam int SRC_REGFILE = 0;

  // Ceiling log2, never less than 1 so derived widths stay legal.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/operand_forward_stage_fwd_select.sv
// Per-operand forwarding match: the youngest valid producer writing the
// operand's register wins; x0 always reads the register file.
module fwd_select
  import operand_forward_stage_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int AW      = DEF_AW,
  parameter int NUM_FWD = 2,
  parameter int SRC_W   = clog2(NUM_FWD + 1)
) (
  input  logic [AW-1:0]           rs_addr,
  input  logic [XLEN-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [NUM_FWD*AW-1:0]   fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic [XLEN-1:0]         sel_data,
  output logic [SRC_W-1:0]        sel_src,
  output logic                    sel_pending
);

  always_comb begin
    sel_data    = rf_data;
    sel_src     = SRC_W'(SRC_REGFILE);
    sel_pending = 1'b0;
    // Scan oldest to youngest so the lowest-index hit overrides the rest.
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      if (fwd_valid[j] && (fwd_rd[j*AW +: AW] == rs_addr) && (rs_addr != '0)) begin
        sel_data    = fwd_data[j*XLEN +: XLEN];
        sel_src     = SRC_W'(j + 1);
        sel_pending = fwd_pending[j];
      end
    end
  end

endmodule

// File: rtl/operand_forward_stage.sv
// ID/EX operand stage: resolves forwarded operands, stalls on load-use
// hazards and registers the result behind a valid/ready handshake.
module operand_forward_stage
  import operand_forward_stage_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int AW      = DEF_AW,
  parameter int NUM_OPS = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16,
  localparam int SRC_W  = clog2(NUM_FWD + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*AW-1:0]    rs_addr,
  input  logic [NUM_OPS*XLEN-1:0]  rf_data,
  input  logic [NUM_FWD-1:0]       fwd_valid,
  input  logic [NUM_FWD-1:0]       fwd_pending,
  input  logic [NUM_FWD*AW-1:0]    fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_OPS*XLEN-1:0]  out_data,
  output logic [NUM_OPS*SRC_W-1:0] out_src,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_OPS*XLEN-1:0]  res_data;
  logic [NUM_OPS*SRC_W-1:0] res_src;
  logic [NUM_OPS-1:0]       res_pending;
  logic                     hazard;
  logic                     load;

  logic                     valid_q, valid_d;
  logic [NUM_OPS*XLEN-1:0]  data_q, data_d;
  logic [NUM_OPS*SRC_W-1:0] src_q, src_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  generate
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
      fwd_select #(
        .XLEN    (XLEN),
        .AW      (AW),
        .NUM_FWD (NUM_FWD),
        .SRC_W   (SRC_W)
      ) u_sel (
        .rs_addr     (rs_addr[gi*AW +: AW]),
        .rf_data     (rf_data[gi*XLEN +: XLEN]),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .sel_data    (res_data[gi*XLEN +: XLEN]),
        .sel_src     (res_src[gi*SRC_W +: SRC_W]),
        .sel_pending (res_pending[gi])
      );
    end
  endgenerate

  assign hazard   = |res_pending;
  assign in_ready = !hazard && (!valid_q || out_ready);
  assign load     = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    // Flush wins; a load accepted in the same cycle is simply dropped.
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = res_data;
      src_d   = res_src;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (in_valid && hazard && !flush && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_operand_forward_stage.sv
// Directed plus randomized bench for operand_forward_stage, checked against
// a behavioural model of the forwarding and handshake rules.
module tb_operand_forward_stage;

  localparam int XLEN  = 64;
  localparam int AW    = 5;
  localparam int NOPS  = 2;
  localparam int NFWD  = 2;
  localparam int CNT_W = 4;
  localparam int SRC_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [NOPS*AW-1:0]      rs_addr;
  logic [NOPS*XLEN-1:0]    rf_data;
  logic [NFWD-1:0]         fwd_valid;
  logic [NFWD-1:0]         fwd_pending;
  logic [NFWD*AW-1:0]      fwd_rd;
  logic [NFWD*XLEN-1:0]    fwd_data;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [NOPS*XLEN-1:0]    out_data;
  logic [NOPS*SRC_W-1:0]   out_src;
  logic [CNT_W-1:0]        stall_cnt;

  operand_forward_stage #(
    .XLEN(XLEN), .AW(AW), .NUM_OPS(NOPS), .NUM_FWD(NFWD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rf_data(rf_data), .fwd_valid(fwd_valid),
    .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: what EX should currently see.
  bit              m_valid;
  logic [XLEN-1:0] m_data [NOPS];
  int              m_src  [NOPS];
  int              m_cnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Which source feeds operand i: first (youngest) matching producer, else regfile.
  function automatic int pick(input int i);
    logic [AW-1:0] a;
    a = rs_addr[i*AW +: AW];
    if (a == 0) return 0;
    for (int j = 0; j < NFWD; j++)
      if (fwd_valid[j] && fwd_rd[j*AW +: AW] == a) return j + 1;
    return 0;
  endfunction

  function automatic logic [XLEN-1:0] opval(input int i);
    int s;
    s = pick(i);
    return (s == 0) ? rf_data[i*XLEN +: XLEN] : fwd_data[(s-1)*XLEN +: XLEN];
  endfunction

  function automatic bit hz();
    int s;
    for (int i = 0; i < NOPS; i++) begin
      s = pick(i);
      if (s != 0 && fwd_pending[s-1]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < NOPS; i++) begin
      m_data[i] = '0;
      m_src[i]  = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 128'(out_valid), 128'(m_valid));
    check({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(m_cnt));
    if (m_valid) begin
      for (int i = 0; i < NOPS; i++) begin
        check($sformatf("%s.data%0d", tag, i), 128'(out_data[i*XLEN +: XLEN]), 128'(m_data[i]));
        check($sformatf("%s.src%0d", tag, i), 128'(out_src[i*SRC_W +: SRC_W]), 128'(m_src[i]));
      end
    end
  endtask

  // Entered just after a negedge with inputs driven; returns at the next negedge.
  task automatic step(input string tag);
    bit h, rdy, ld;
    logic [XLEN-1:0] nd [NOPS];
    int ns [NOPS];
    #1;
    h   = hz();
    rdy = !h && (!m_valid || out_ready);
    ld  = in_valid && rdy;
    for (int i = 0; i < NOPS; i++) begin
      nd[i] = opval(i);
      ns[i] = pick(i);
    end
    check({tag, ".in_ready"}, 128'(in_ready), 128'(rdy));
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (ld) begin
      m_valid = 1'b1;
      for (int i = 0; i < NOPS; i++) begin
        m_data[i] = nd[i];
        m_src[i]  = ns[i];
      end
    end else if (out_ready) m_valid = 1'b0;
    if (in_valid && h && !flush && m_cnt < CMAX) m_cnt++;
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    rs_addr[i*AW +: AW]     = a;
    rf_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic set_fwd(input int j, input bit v, input bit p, input logic [AW-1:0] rd,
                         input logic [XLEN-1:0] d);
    fwd_valid[j]              = v;
    fwd_pending[j]            = p;
    fwd_rd[j*AW +: AW]        = rd;
    fwd_data[j*XLEN +: XLEN]  = d;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check({tag, ".rst_valid"}, 128'(out_valid), 128'(0));
    check({tag, ".rst_cnt"}, 128'(stall_cnt), 128'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; out_ready = 0; flush = 0;
    rs_addr = '0; rf_data = '0; fwd_valid = '0; fwd_pending = '0; fwd_rd = '0; fwd_data = '0;
    model_reset();
    #3;
    check("reset.out_valid", 128'(out_valid), 128'(0));
    check("reset.out_data", 128'(out_data), 128'(0));
    check("reset.out_src", 128'(out_src), 128'(0));
    check("reset.stall_cnt", 128'(stall_cnt), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    // Plain register-file operands.
    set_op(0, 5, 64'h11); set_op(1, 6, 64'h22);
    in_valid = 1; out_ready = 1;
    step("regfile");
    check("regfile.op0", 128'(out_data[63:0]), 128'(64'h11));
    check("regfile.op1", 128'(out_data[127:64]), 128'(64'h22));
    check("regfile.src", 128'(out_src), 128'(0));

    // Youngest producer wins over an older one.
    set_op(0, 7, 64'h77);
    set_fwd(0, 1, 0, 7, 64'hAAAA); set_fwd(1, 1, 0, 7, 64'hBBBB);
    step("priority");
    check("priority.op0", 128'(out_data[63:0]), 128'(64'hAAAA));
    check("priority.src0", 128'(out_src[1:0]), 128'(1));

    // x0 never forwards.
    set_op(0, 0, 64'h55);
    set_fwd(0, 1, 0, 0, 64'hAAAA); set_fwd(1, 1, 0, 0, 64'hBBBB);
    step("x0");
    check("x0.op0", 128'(out_data[63:0]), 128'(64'h55));
    check("x0.src0", 128'(out_src[1:0]), 128'(0));

    // Load-use: two stalled cycles, then the producer resolves.
    set_op(0, 5, 64'h11); set_op(1, 9, 64'h99);
    set_fwd(0, 1, 1, 9, 64'hDEAD); set_fwd(1, 0, 0, 0, 64'h0);
    step("loaduse1");
    check("loaduse1.in_ready", 128'(in_ready), 128'(0));
    step("loaduse2");
    set_fwd(0, 1, 0, 9, 64'h1234);
    step("loaduse3");
    check("loaduse.op1", 128'(out_data[127:64]), 128'(64'h1234));
    check("loaduse.src1", 128'(out_src[3:2]), 128'(1));
    check("loaduse.cnt", 128'(stall_cnt), 128'(2));

    // Backpressure: held for three cycles, then drain and load together.
    set_fwd(0, 0, 0, 0, 64'h0);
    set_op(0, 3, 64'h33); set_op(1, 4, 64'h44);
    out_ready = 0;
    for (int k = 0; k < 3; k++) step($sformatf("hold%0d", k));
    check("hold.op1", 128'(out_data[127:64]), 128'(64'h1234));
    out_ready = 1;
    step("drainload");
    check("drainload.data", 128'(out_data), 128'({64'h44, 64'h33}));

    // Flush discards the concurrent load.
    flush = 1;
    step("flush");
    check("flush.out_valid", 128'(out_valid), 128'(0));
    flush = 0;

    // Reset while held and stalled.
    out_ready = 0;
    step("preload");
    set_fwd(0, 1, 1, 4, 64'h0);
    step("stallA");
    step("stallB");
    async_reset("midstall");

    // Counter saturation with a long hazard.
    for (int k = 0; k < 20; k++) step($sformatf("sat%0d", k));
    check("sat.cnt", 128'(stall_cnt), 128'(15));

    // Randomized traffic.
    async_reset("randstart");
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1);
      flush     = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NOPS; i++)
        set_op(i, AW'($urandom_range(0, 3)), {$urandom, $urandom});
      for (int j = 0; j < NFWD; j++)
        set_fwd(j, $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                AW'($urandom_range(0, 3)), {$urandom, $urandom});
      step($sformatf("rand%0d", k));
      if ($urandom_range(0, 59) == 0) async_reset($sformatf("randrst%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_forward_stage.md
Name: operand_forward_stage

Overview:
- Parametrised successor to the fixed 3-input 64-bit forwarding select. Resolves NUM_OPS source operands against NUM_FWD in-flight producers (EX/MEM, MEM/WB, ...).
- Detects load-use hazards and stalls until the pending producer resolves.
- Registers the resolved operands into the ID/EX boundary with a valid/ready handshake, flush and a stall-cycle counter.
- Sits between register-file read (ID) and ALU input (EX).

Parameters:
- XLEN, 64, operand data width.
- AW, 5, register address width.
- NUM_OPS, 2, operands resolved per instruction (rs1, rs2, ...).
- NUM_FWD, 2, forwarding sources; index 0 = youngest (EX/MEM), highest priority.
- CNT_W, 16, stall counter width.
- Derived localparam SRC_W = clog2(NUM_FWD+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  ID-side instruction valid.
- in_ready  out  1  stage can accept this cycle.
- rs_addr  in  NUM_OPS*AW  source register addresses; op i at [i*AW +: AW].
- rf_data  in  NUM_OPS*XLEN  register-file read data per op.
- fwd_valid  in  NUM_FWD  producer j writes a register.
- fwd_pending  in  NUM_FWD  producer j data not yet available (load in flight).
- fwd_rd  in  NUM_FWD*AW  producer destination addresses.
- fwd_data  in  NUM_FWD*XLEN  producer result data.
- flush  in  1  kill stage contents (branch mispredict).
- out_valid  out  1  registered operands valid.
- out_ready  in  1  EX consumes this cycle.
- out_data  out  NUM_OPS*XLEN  resolved operands.
- out_src  out  NUM_OPS*SRC_W  per-op source: 0 = regfile, j+1 = producer j.
- stall_cnt  out  CNT_W  hazard-stall cycle count.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_src=0, stall_cnt=0.
- Per op i: hit_j = fwd_valid[j] && fwd_rd[j]==rs_addr[i] && rs_addr[i]!=0. Register x0 is never forwarded; its operand is always rf_data (expected 0).
- Selection: the lowest j with hit_j wins, giving sel=j+1 and data=fwd_data[j]. With no hit, sel=0 and data=rf_data[i]. Older matching producers are ignored.
- hazard = OR over ops of (winning producer has fwd_pending=1). A pending older producer shadowed by a younger non-pending hit causes no hazard.
- in_ready = !hazard && (!out_valid || out_ready). This is combinational and depends on current inputs only.
- Load condition: in_valid && in_ready. On load, out_data/out_src capture the resolved values at the edge and out_valid becomes 1. Latency is 1 cycle.
- Drain: out_valid && out_ready && !load clears out_valid to 0.
- Hold: out_valid && !out_ready keeps outputs stable. in_ready is 0 in this state.
- Flush: takes priority over load and hold. Next cycle out_valid=0; out_data/out_src keep their old values (don't-care). in_ready is not gated by flush, but any load in a flush cycle is discarded.
- stall_cnt increments each cycle where in_valid && hazard && !flush. It saturates at all-ones and does not wrap. It is cleared only by reset.
- Simultaneous drain and load: out_valid stays 1 with new data, giving back-to-back throughput of 1/cycle.
- Reset mid-operation: a stalled or held instruction is lost; the upstream stage must re-present it.

Decomposition:
- Shared package/header: SRC_REGFILE=0 encoding, AW/XLEN defaults, clog2 function.
- One sub-module, fwd_select: combinational per-operand priority match plus pending flag. Instantiate it NUM_OPS times via generate.
- The top level holds the pipeline register, handshake and counter.

Test Plan:
- Operand selection: rs1=5, rs2=6, no hits, rf_data=0x11/0x22, in_valid=1, out_ready=1 → next cycle out_valid=1, out_data=0x11/0x22, out_src=0/0.
- Priority: rs1=7, producer0 rd=7 data=0xAAAA, producer1 rd=7 data=0xBBBB (both valid, not pending) → out_data op0=0xAAAA, out_src=1. Repeat with rs1=0 and both rd=0 → regfile value, out_src=0.
- Load-use: rs2=9, producer0 rd=9 pending for 2 cycles, then data=0x1234 → in_ready=0 for 2 cycles, stall_cnt=2, third cycle load gives out_data op1=0x1234, out_src=1.
- Backpressure: out_ready=0 for 3 cycles with new in_valid → outputs unchanged, in_ready=0; out_ready=1 → drain and new load in the same cycle.
- Flush and reset: flush asserted with in_valid=1 → out_valid=0 next cycle. Async reset asserted mid-stall → out_valid=0, stall_cnt=0 immediately.
- Saturation: CNT_W=4, hold hazard for 20 cycles → stall_cnt=15.
